// File: rtl/gbf_ctrl_pkg.sv
// Shared encodings for the GBF write controller: pending-op codes and FSM states.
package gbf_ctrl_pkg;

  // Op codes are ordered by priority so that a plain magnitude compare
  // answers "does this event outrank the pending op".
  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_RSTGRP = 2'd1,
    OP_NEXT   = 2'd2,
    OP_LAY    = 2'd3
  } opT;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_CFG = 1'b1
  } stateT;

  // Collapse the three event pulses into the single highest-priority op.
  function automatic opT pickOp(input logic lay, input logic nxt, input logic rstGrp);
    opT op;
    op = OP_NONE;
    if (lay)         op = OP_LAY;
    else if (nxt)    op = OP_NEXT;
    else if (rstGrp) op = OP_RSTGRP;
    return op;
  endfunction

  // A new event replaces the pending op only when it strictly outranks it.
  function automatic opT mergeOp(input opT pend, input opT ev);
    opT op;
    op = pend;
    if (ev > pend) op = ev;
    return op;
  endfunction

endpackage

// File: rtl/gbf_grp_tbl.sv
// Feature-group base-address table: one synchronous write port, two
// asynchronous read ports (current group and the group after it).
module gbf_grp_tbl
  import gbf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int GRP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [GRP_WIDTH-1:0]  wrIdx,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [GRP_WIDTH-1:0]  rdIdxA,
  output logic [ADDR_WIDTH-1:0] rdAddrA,
  input  logic [GRP_WIDTH-1:0]  rdIdxB,
  output logic [ADDR_WIDTH-1:0] rdAddrB
);

  localparam int Depth = 2 ** GRP_WIDTH;

  logic [ADDR_WIDTH-1:0] mem [Depth];

  // Table write; a same-edge read of the written index still sees the old entry.
  // NOTE: the table has no reset on purpose -- entries are host-programmed and a
  // controller reset must not erase them; it also keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wrIdx] <= wrAddr;
  end

  assign rdAddrA = mem[rdIdxA];
  assign rdAddrB = mem[rdIdxB];

endmodule

// File: rtl/gbf_wr_ctrl.sv
// GBF write controller: streams upstream words into the global buffer at a
// running write address, and re-bases that address on layer/group events
// once the read path reports its reconfiguration is complete.
module gbf_wr_ctrl #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 20,
  parameter int GRP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Reset_FtrLay,
  input  logic                  Next_FtrGrp,
  input  logic                  Reset_FtrGrp,
  input  logic                  cfg_done,
  input  logic                  tbl_we,
  input  logic [GRP_WIDTH-1:0]  tbl_idx,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  in_rdy,
  output logic                  GBF_EnWr,
  output logic [ADDR_WIDTH-1:0] GBF_AddrWr,
  output logic [DATA_WIDTH-1:0] GBF_DatWr,
  output logic [GRP_WIDTH-1:0]  grp_idx,
  output logic                  busy,
  output logic                  err_ovf
);

  import gbf_ctrl_pkg::*;

  // Registered state and its next-cycle values.
  stateT                 state,    stateNxt;
  opT                    pendOp,   pendOpNxt;
  logic [GRP_WIDTH-1:0]  grp,      grpNxt;
  logic [ADDR_WIDTH-1:0] wrAddr,   wrAddrNxt;
  logic                  ovf,      ovfNxt;
  logic                  enWrNxt;
  logic [ADDR_WIDTH-1:0] addrWrNxt;
  logic [DATA_WIDTH-1:0] datWrNxt;

  // Event decode and handshake.
  opT                    evOp;
  opT                    mergedOp;
  logic                  anyEv;
  logic                  xfer;
  logic [GRP_WIDTH-1:0]  grpPlus1;
  logic [ADDR_WIDTH-1:0] tblCurAddr;
  logic [ADDR_WIDTH-1:0] tblNxtAddr;

  assign evOp     = pickOp(Reset_FtrLay, Next_FtrGrp, Reset_FtrGrp);
  assign anyEv    = (evOp != OP_NONE);
  assign mergedOp = mergeOp(pendOp, evOp);
  assign grpPlus1 = grp + GRP_WIDTH'(1);

  // Upstream is held off while reconfiguring and in any cycle an event arrives,
  // so no word is written against an address that is about to be re-based.
  assign in_rdy = (state == ST_RUN) && !anyEv;
  assign xfer   = in_vld && in_rdy;

  gbf_grp_tbl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .GRP_WIDTH  (GRP_WIDTH)
  ) u_grp_tbl (
    .clk     (clk),
    .we      (tbl_we),
    .wrIdx   (tbl_idx),
    .wrAddr  (tbl_addr),
    .rdIdxA  (grp),
    .rdAddrA (tblCurAddr),
    .rdIdxB  (grpPlus1),
    .rdAddrB (tblNxtAddr)
  );

  // Next-state, op bookkeeping and write-path decisions.
  // NOTE: every value is given its hold/default first so no path through the
  // case statement leaves a variable unassigned, which would infer a latch.
  always_comb begin
    stateNxt  = state;
    pendOpNxt = pendOp;
    grpNxt    = grp;
    wrAddrNxt = wrAddr;
    ovfNxt    = ovf;
    enWrNxt   = 1'b0;
    addrWrNxt = GBF_AddrWr;
    datWrNxt  = GBF_DatWr;

    case (state)
      ST_RUN: begin
        if (anyEv) begin
          stateNxt  = ST_WAIT_CFG;
          pendOpNxt = evOp;
        end
        if (xfer) begin
          enWrNxt   = 1'b1;
          addrWrNxt = wrAddr;
          datWrNxt  = in_dat;
          wrAddrNxt = wrAddr + ADDR_WIDTH'(1);
          if (&wrAddr) ovfNxt = 1'b1;
        end
      end

      ST_WAIT_CFG: begin
        if (cfg_done) begin
          stateNxt  = ST_RUN;
          pendOpNxt = OP_NONE;
          case (mergedOp)
            OP_LAY: begin
              grpNxt    = '0;
              wrAddrNxt = '0;
            end
            OP_NEXT: begin
              grpNxt    = grpPlus1;
              wrAddrNxt = tblNxtAddr;
              if (&grp) ovfNxt = 1'b1;
            end
            OP_RSTGRP: begin
              wrAddrNxt = tblCurAddr;
            end
            default: ;
          endcase
        end else begin
          pendOpNxt = mergedOp;
        end
      end

      default: stateNxt = ST_RUN;
    endcase
  end

  // State and datapath registers with synchronous reset; table is untouched.
  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pendOp     <= OP_NONE;
      grp        <= '0;
      wrAddr     <= '0;
      ovf        <= 1'b0;
      GBF_EnWr   <= 1'b0;
      GBF_AddrWr <= '0;
      GBF_DatWr  <= '0;
    end else begin
      state      <= stateNxt;
      pendOp     <= pendOpNxt;
      grp        <= grpNxt;
      wrAddr     <= wrAddrNxt;
      ovf        <= ovfNxt;
      GBF_EnWr   <= enWrNxt;
      GBF_AddrWr <= addrWrNxt;
      GBF_DatWr  <= datWrNxt;
    end
  end

  assign busy    = (state == ST_WAIT_CFG);
  assign grp_idx = grp;
  assign err_ovf = ovf;

endmodule

// File: tb/tb_gbf_wr_ctrl.sv
// Directed bench for gbf_wr_ctrl: streaming, group events, priority/upgrade,
// table write-through timing, address and group wrap, and reset behaviour.
module tb_gbf_wr_ctrl;

  localparam int DW = 96;
  localparam int AW = 20;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          Reset_FtrLay, Next_FtrGrp, Reset_FtrGrp, cfg_done;
  logic          tbl_we;
  logic [GW-1:0] tbl_idx;
  logic [AW-1:0] tbl_addr;
  logic          in_vld;
  logic [DW-1:0] in_dat;
  logic          in_rdy, GBF_EnWr, busy, err_ovf;
  logic [AW-1:0] GBF_AddrWr;
  logic [DW-1:0] GBF_DatWr;
  logic [GW-1:0] grp_idx;

  int total = 0;
  int bad   = 0;

  gbf_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRP_WIDTH(GW)) dut (
    .clk          (clk),
    .rst          (rst),
    .Reset_FtrLay (Reset_FtrLay),
    .Next_FtrGrp  (Next_FtrGrp),
    .Reset_FtrGrp (Reset_FtrGrp),
    .cfg_done     (cfg_done),
    .tbl_we       (tbl_we),
    .tbl_idx      (tbl_idx),
    .tbl_addr     (tbl_addr),
    .in_vld       (in_vld),
    .in_dat       (in_dat),
    .in_rdy       (in_rdy),
    .GBF_EnWr     (GBF_EnWr),
    .GBF_AddrWr   (GBF_AddrWr),
    .GBF_DatWr    (GBF_DatWr),
    .grp_idx      (grp_idx),
    .busy         (busy),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for exactly one cycle.
  task automatic pushWord(input logic [DW-1:0] d);
    in_vld = 1'b1;
    in_dat = d;
    step();
    in_vld = 1'b0;
  endtask

  task automatic pulseNext();
    Next_FtrGrp = 1'b1; step(); Next_FtrGrp = 1'b0;
  endtask

  task automatic pulseRstGrp();
    Reset_FtrGrp = 1'b1; step(); Reset_FtrGrp = 1'b0;
  endtask

  task automatic pulseCfg();
    cfg_done = 1'b1; step(); cfg_done = 1'b0;
  endtask

  task automatic loadTable();
    for (int i = 0; i < 16; i++) begin
      tbl_we   = 1'b1;
      tbl_idx  = i[GW-1:0];
      tbl_addr = (i == 2) ? 20'hFFFFF : AW'(i * 256);
      step();
    end
    tbl_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    total++; if (GBF_EnWr !== 1'b0) begin bad++; $display("FAIL reset_enwr got=%b want=0", GBF_EnWr); end
    total++; if (GBF_AddrWr !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=00000", GBF_AddrWr); end
    total++; if (GBF_DatWr !== 96'h0) begin bad++; $display("FAIL reset_dat got=%h want=0", GBF_DatWr); end
    total++; if (grp_idx !== 4'h0) begin bad++; $display("FAIL reset_grp got=%h want=0", grp_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", err_ovf); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", in_rdy); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] w [3];
    w[0] = 96'hA0A0_0000_1111_2222_3333_0001;
    w[1] = 96'hB1B1_4444_5555_6666_7777_0002;
    w[2] = 96'hC2C2_8888_9999_AAAA_BBBB_0003;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      in_dat = w[i];
      #1;
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL stream_rdy[%0d] got=%b want=1", i, in_rdy); end
      @(posedge clk); #1;
      total++; if (GBF_EnWr !== 1'b1) begin bad++; $display("FAIL stream_enwr[%0d] got=%b want=1", i, GBF_EnWr); end
      total++; if (GBF_AddrWr !== AW'(i)) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, GBF_AddrWr, AW'(i)); end
      total++; if (GBF_DatWr !== w[i]) begin bad++; $display("FAIL stream_dat[%0d] got=%h want=%h", i, GBF_DatWr, w[i]); end
    end
    in_vld = 1'b0;
    step();
    total++; if (GBF_EnWr !== 1'b0) begin bad++; $display("FAIL idle_enwr got=%b want=0", GBF_EnWr); end
    total++; if (GBF_AddrWr !== 20'h00002) begin bad++; $display("FAIL idle_addr_hold got=%h want=00002", GBF_AddrWr); end
    total++; if (GBF_DatWr !== w[2]) begin bad++; $display("FAIL idle_dat_hold got=%h want=%h", GBF_DatWr, w[2]); end
  endtask

  task automatic test_next_grp();
    Next_FtrGrp = 1'b1;
    #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL next_ev_rdy got=%b want=0", in_rdy); end
    step();
    Next_FtrGrp = 1'b0;
    in_vld = 1'b1;
    in_dat = 96'hDEAD;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy[%0d] got=%b want=1", c, busy); end
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL wait_rdy[%0d] got=%b want=0", c, in_rdy); end
      total++; if (GBF_EnWr !== 1'b0) begin bad++; $display("FAIL wait_enwr[%0d] got=%b want=0", c, GBF_EnWr); end
      if (c == 3) cfg_done = 1'b1;
      @(posedge clk); #1;
    end
    cfg_done = 1'b0;
    in_vld   = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL next_busy_clr got=%b want=0", busy); end
    total++; if (grp_idx !== 4'h1) begin bad++; $display("FAIL next_grp got=%h want=1", grp_idx); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL next_rdy got=%b want=1", in_rdy); end
    pushWord(96'h0000_0000_0000_0000_0000_1234);
    total++; if (GBF_EnWr !== 1'b1) begin bad++; $display("FAIL next_enwr got=%b want=1", GBF_EnWr); end
    total++; if (GBF_AddrWr !== 20'h00100) begin bad++; $display("FAIL next_addr got=%h want=00100", GBF_AddrWr); end
    total++; if (GBF_DatWr !== 96'h1234) begin bad++; $display("FAIL next_dat got=%h want=1234", GBF_DatWr); end
  endtask

  task automatic test_reset_grp();
    for (int i = 1; i < 5; i++) begin
      pushWord(DW'(i));
      total++; if (GBF_AddrWr !== AW'(20'h100 + i)) begin bad++; $display("FAIL grp1_addr[%0d] got=%h want=%h", i, GBF_AddrWr, AW'(20'h100 + i)); end
    end
    pulseRstGrp();
    pulseCfg();
    total++; if (grp_idx !== 4'h1) begin bad++; $display("FAIL rstgrp_grp got=%h want=1", grp_idx); end
    pushWord(96'h55);
    total++; if (GBF_AddrWr !== 20'h00100) begin bad++; $display("FAIL rstgrp_addr got=%h want=00100", GBF_AddrWr); end
  endtask

  task automatic test_tbl_same_cycle();
    pulseRstGrp();
    cfg_done = 1'b1;
    tbl_we   = 1'b1;
    tbl_idx  = 4'h1;
    tbl_addr = 20'h03333;
    step();
    cfg_done = 1'b0;
    tbl_we   = 1'b0;
    pushWord(96'h66);
    total++; if (GBF_AddrWr !== 20'h00100) begin bad++; $display("FAIL tbl_old_value got=%h want=00100", GBF_AddrWr); end
    pulseRstGrp();
    pulseCfg();
    pushWord(96'h77);
    total++; if (GBF_AddrWr !== 20'h03333) begin bad++; $display("FAIL tbl_new_value got=%h want=03333", GBF_AddrWr); end
  endtask

  task automatic test_priority();
    Next_FtrGrp  = 1'b1;
    Reset_FtrLay = 1'b1;
    step();
    Next_FtrGrp  = 1'b0;
    Reset_FtrLay = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL prio_busy got=%b want=1", busy); end
    pulseCfg();
    total++; if (grp_idx !== 4'h0) begin bad++; $display("FAIL prio_lay_grp got=%h want=0", grp_idx); end
    pushWord(96'h88);
    total++; if (GBF_AddrWr !== 20'h00000) begin bad++; $display("FAIL prio_lay_addr got=%h want=00000", GBF_AddrWr); end
    // RSTGRP pending, NEXT arrives while waiting: upgraded to NEXT.
    pulseRstGrp();
    pulseNext();
    pulseCfg();
    total++; if (grp_idx !== 4'h1) begin bad++; $display("FAIL upgrade_grp got=%h want=1", grp_idx); end
    pushWord(96'h99);
    total++; if (GBF_AddrWr !== 20'h03333) begin bad++; $display("FAIL upgrade_addr got=%h want=03333", GBF_AddrWr); end
    // NEXT pending, RSTGRP coincident with cfg_done: ignored, NEXT applies.
    pulseNext();
    Reset_FtrGrp = 1'b1;
    cfg_done     = 1'b1;
    step();
    Reset_FtrGrp = 1'b0;
    cfg_done     = 1'b0;
    total++; if (grp_idx !== 4'h2) begin bad++; $display("FAIL no_downgrade_grp got=%h want=2", grp_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL no_downgrade_busy got=%b want=0", busy); end
  endtask

  task automatic test_addr_wrap();
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL wrap_pre_ovf got=%b want=0", err_ovf); end
    pushWord(96'hAA);
    total++; if (GBF_AddrWr !== 20'hFFFFF) begin bad++; $display("FAIL wrap_last_addr got=%h want=fffff", GBF_AddrWr); end
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b want=1", err_ovf); end
    pushWord(96'hBB);
    total++; if (GBF_AddrWr !== 20'h00000) begin bad++; $display("FAIL wrap_zero_addr got=%h want=00000", GBF_AddrWr); end
    pulseCfg();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_in_run_busy got=%b want=0", busy); end
    total++; if (grp_idx !== 4'h2) begin bad++; $display("FAIL cfg_in_run_grp got=%h want=2", grp_idx); end
    pushWord(96'hCC);
    total++; if (GBF_AddrWr !== 20'h00001) begin bad++; $display("FAIL cfg_in_run_addr got=%h want=00001", GBF_AddrWr); end
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf_sticky got=%b want=1", err_ovf); end
  endtask

  task automatic test_rst_in_wait();
    pulseNext();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstwait_busy got=%b want=1", busy); end
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstwait_busy_clr got=%b want=0", busy); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL rstwait_ovf got=%b want=0", err_ovf); end
    total++; if (GBF_AddrWr !== 20'h0) begin bad++; $display("FAIL rstwait_addr got=%h want=00000", GBF_AddrWr); end
    pulseCfg();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstwait_cfg_busy got=%b want=0", busy); end
    total++; if (grp_idx !== 4'h0) begin bad++; $display("FAIL rstwait_cfg_grp got=%h want=0", grp_idx); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL rstwait_cfg_rdy got=%b want=1", in_rdy); end
    // Reset coincident with a transfer suppresses it.
    in_vld = 1'b1;
    in_dat = 96'hEE;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    in_vld = 1'b0;
    total++; if (GBF_EnWr !== 1'b0) begin bad++; $display("FAIL rst_xfer_enwr got=%b want=0", GBF_EnWr); end
    total++; if (GBF_DatWr !== 96'h0) begin bad++; $display("FAIL rst_xfer_dat got=%h want=0", GBF_DatWr); end
    pushWord(96'hFF);
    total++; if (GBF_AddrWr !== 20'h00000) begin bad++; $display("FAIL rst_xfer_addr got=%h want=00000", GBF_AddrWr); end
  endtask

  task automatic test_grp_wrap();
    for (int k = 1; k < 16; k++) begin
      pulseNext();
      pulseCfg();
    end
    total++; if (grp_idx !== 4'hF) begin bad++; $display("FAIL grp15_idx got=%h want=f", grp_idx); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL grp15_ovf got=%b want=0", err_ovf); end
    pushWord(96'h101);
    total++; if (GBF_AddrWr !== 20'h00F00) begin bad++; $display("FAIL grp15_addr got=%h want=00f00", GBF_AddrWr); end
    pulseNext();
    pulseCfg();
    total++; if (grp_idx !== 4'h0) begin bad++; $display("FAIL grpwrap_idx got=%h want=0", grp_idx); end
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL grpwrap_ovf got=%b want=1", err_ovf); end
    pushWord(96'h202);
    total++; if (GBF_AddrWr !== 20'h00000) begin bad++; $display("FAIL grpwrap_addr got=%h want=00000", GBF_AddrWr); end
  endtask

  initial begin
    rst          = 1'b1;
    Reset_FtrLay = 1'b0;
    Next_FtrGrp  = 1'b0;
    Reset_FtrGrp = 1'b0;
    cfg_done     = 1'b0;
    tbl_we       = 1'b0;
    tbl_idx      = '0;
    tbl_addr     = '0;
    in_vld       = 1'b0;
    in_dat       = '0;
    test_reset();
    loadTable();
    test_stream();
    test_next_grp();
    test_reset_grp();
    test_tbl_same_cycle();
    test_priority();
    test_addr_wrap();
    test_rst_in_wait();
    test_grp_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
